butterfly_wb_writer: RTL and testbench
======================================

BUTTERFLY_WB_WRITER -- requirements
Module: butterfly_wb_writer

Interface
REQ-001 SHALL have parameter data_width, default 16, meaning per-lane result data width.
REQ-002 SHALL have parameter bu_parallelism, default 8, meaning lanes per beat (power of two, >=8).
REQ-003 SHALL have parameter fifo_depth, default 4, meaning beats buffered between index/data input and write port.
REQ-004 SHALL have clk  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have start  input  1  one-cycle pulse beginning a transform.
REQ-007 SHALL have length  input  32  transform length (128..4096, power of two), sampled on start.
REQ-008 SHALL have in_vld  input  1  index/data beat valid.
REQ-009 SHALL have in_rdy  output  1  beat accepted when in_vld && in_rdy.
REQ-010 SHALL have in_indx  input  32*bu_parallelism  lane k index at bits [32k+31:32k], in butterfly index-generator lane order.
REQ-011 SHALL have in_data  input  data_width*bu_parallelism  lane k result at bits [data_width*k+data_width-1:data_width*k].
REQ-012 SHALL have wr_vld  output  1  write beat valid.
REQ-013 SHALL have wr_rdy  input  1  memory accepts beat when wr_vld && wr_rdy.
REQ-014 SHALL have wr_en  output  bu_parallelism  per-lane write enable.
REQ-015 SHALL have wr_addr  output  12*bu_parallelism  lane k address = in_indx lane k bits [11:0].
REQ-016 SHALL have wr_data  output  data_width*bu_parallelism  lane k data, passed unmodified.
REQ-017 SHALL have write_finish  output  1  one-cycle pulse when final beat is written.
REQ-018 SHALL have err_oob  output  1  sticky: some accepted lane index >= latched length.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start with legal length; RUN->DRAIN when accepted beats == expected; DRAIN->IDLE when written beats == expected.
REQ-020 SHALL compute expected beats = (length/bu_parallelism)*log2(length) at start (length 128, P=8 -> 112; length 4096 -> 6144).
REQ-021 SHALL ignore start with illegal length (not a power of two in 128..4096) and remain IDLE.
REQ-022 SHALL ignore start while in RUN or DRAIN.
REQ-023 SHALL drive in_rdy = (state==RUN) && FIFO not full, combinationally from registered state/occupancy only.
REQ-024 SHALL, on a push, store all lanes of in_indx[11:0]-per-lane, in_data, and per-lane in-range flag.
REQ-025 SHALL present a pushed beat on wr_* no earlier than the cycle after the push (registered FIFO output); wr_vld = FIFO not empty.
REQ-026 SHALL hold wr_* stable while wr_vld && !wr_rdy.
REQ-027 SHALL keep occupancy unchanged on simultaneous push and pop; push into full FIFO SHALL not occur (in_rdy low).
REQ-028 SHALL set wr_en lane k = wr_vld && lane k in range (index < length); out-of-range lanes masked and err_oob set the cycle after the push.
REQ-029 SHALL pulse write_finish the cycle after the final pop, state IDLE that same cycle.
REQ-030 SHALL clear err_oob on the next legal start; beat counters SHALL clear on start.
REQ-031 SHALL wrap FIFO read/write pointers modulo fifo_depth.

Reset
REQ-032 SHALL on rst_n low: state IDLE, FIFO empty, counters 0, in_rdy 0, wr_vld 0, wr_en 0, wr_addr 0, wr_data 0, write_finish 0, err_oob 0.
REQ-033 SHALL abandon any transform on reset mid-operation; no write_finish issued for it.

Structure
REQ-034 SHALL place MAX_LENGTH=4096, ADDR_W=12, legal-length check and state encoding in shared package butterfly_pkg.
REQ-035 SHALL implement the buffer as sub-module butterfly_wb_fifo (synchronous, first-word-registered, parameterised width/depth).

Verification
REQ-036 SHALL cover: start length=128, in_vld always 1, wr_rdy always 1 -> 112 beats written, write_finish one pulse, err_oob 0.
REQ-037 SHALL cover: wr_rdy low 10 cycles mid-stream -> in_rdy low after 4 buffered beats, wr_* stable, no beat lost or duplicated.
REQ-038 SHALL cover: length=128, one lane index 130 -> that lane wr_en 0, other 7 lanes 1, err_oob 1 until next start.
REQ-039 SHALL cover: start with length=100 -> state stays IDLE, in_rdy 0; start during RUN -> counters unchanged.
REQ-040 SHALL cover: rst_n low after 50 beats of length=256 -> all outputs 0 next cycle, write_finish never pulses; fresh start then completes 256 beats.

Source files
------------

// File: rtl/butterfly_pkg.sv
// Shared constants, state encoding and length helpers for the butterfly write-back path.
package butterfly_pkg;

    localparam int unsigned MAX_LENGTH = 4096;
    localparam int unsigned MIN_LENGTH = 128;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned LEN_W      = 13;   // holds MAX_LENGTH itself
    localparam int unsigned CNT_W      = 16;   // beat counters, max 6144 beats
    localparam int unsigned STATE_W    = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;

    // Power of two within MIN_LENGTH..MAX_LENGTH.
    function automatic logic is_legal_length(input logic [31:0] len);
        return (len >= 32'(MIN_LENGTH)) && (len <= 32'(MAX_LENGTH)) &&
               ((len & (len - 32'd1)) == 32'd0);
    endfunction

    // Position of the highest set bit; equals log2 for a power of two.
    function automatic logic [3:0] log2_length(input logic [LEN_W-1:0] len);
        logic [3:0] r;
        r = 4'd0;
        for (int unsigned b = 0; b < LEN_W; b++) begin
            if (len[b]) r = 4'(b);
        end
        return r;
    endfunction

endpackage

// File: rtl/butterfly_wb_fifo.sv
// Small ring-buffer FIFO whose head entry sits in a dedicated output register.
// The head register is cleared when the FIFO empties so downstream sees zeros.
module butterfly_wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             vld_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_inc;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             do_push, do_pop;

    assign do_push    = push_i && (occ_q != OCC_W'(DEPTH));
    assign do_pop     = pop_i && vld_q;
    assign wr_ptr_inc = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    assign rd_ptr_inc = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);

    assign dout_o = dout_q;
    assign vld_o  = vld_q;
    assign full_o = (occ_q == OCC_W'(DEPTH));

    // Next pointers, occupancy and head-register contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        dout_d   = dout_q;

        if (do_push) wr_ptr_d = wr_ptr_inc;
        if (do_pop)  rd_ptr_d = rd_ptr_inc;

        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Head follows the oldest entry; a push into an emptying FIFO bypasses the ring.
        if (occ_q == '0) begin
            if (do_push) dout_d = din_i;
        end else if (do_pop) begin
            if (occ_q >= OCC_W'(2))  dout_d = mem_q[rd_ptr_inc];
            else if (do_push)        dout_d = din_i;
            else                     dout_d = '0;
        end

        vld_d = (occ_d != '0);
    end

    // Ring storage; contents only read while valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Control and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
        end
    end

endmodule

// File: rtl/butterfly_wb_writer.sv
// Butterfly result write-back: buffers index/data beats and writes them to
// lane-parallel memory, masking lanes whose index falls outside the transform.
module butterfly_wb_writer
    import butterfly_pkg::*;
#(
    parameter int unsigned data_width     = 16,
    parameter int unsigned bu_parallelism = 8,
    parameter int unsigned fifo_depth     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [31:0]                          length,
    input  logic                                 in_vld,
    output logic                                 in_rdy,
    input  logic [32*bu_parallelism-1:0]         in_indx,
    input  logic [data_width*bu_parallelism-1:0] in_data,
    output logic                                 wr_vld,
    input  logic                                 wr_rdy,
    output logic [bu_parallelism-1:0]            wr_en,
    output logic [ADDR_W*bu_parallelism-1:0]     wr_addr,
    output logic [data_width*bu_parallelism-1:0] wr_data,
    output logic                                 write_finish,
    output logic                                 err_oob
);

    localparam int unsigned P          = bu_parallelism;
    localparam int unsigned LOG2P      = $clog2(P);
    localparam int unsigned DATA_BUS_W = data_width * P;
    localparam int unsigned ADDR_BUS_W = ADDR_W * P;
    localparam int unsigned ENTRY_W    = P + ADDR_BUS_W + DATA_BUS_W;

    logic [STATE_W-1:0] state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic               err_q, err_d;
    logic               fin_q, fin_d;

    logic [P-1:0]          lane_ok;
    logic [ADDR_BUS_W-1:0] lane_addr;
    logic [CNT_W-1:0]      beats_per_stage;
    logic [CNT_W-1:0]      start_exp;
    logic                  start_ok;
    logic                  accept;
    logic                  wr_fire;

    logic [ENTRY_W-1:0] fifo_din, fifo_dout;
    logic               fifo_vld, fifo_full;

    // Per-lane address slice and range check against the latched length.
    always_comb begin
        lane_addr = '0;
        lane_ok   = '0;
        for (int unsigned k = 0; k < P; k++) begin
            lane_addr[k*ADDR_W +: ADDR_W] = in_indx[k*32 +: ADDR_W];
            lane_ok[k] = (in_indx[k*32 +: 32] < 32'(len_q));
        end
    end

    assign start_ok        = start && is_legal_length(length);
    assign beats_per_stage = CNT_W'(length[LEN_W-1:0] >> LOG2P);
    assign start_exp       = beats_per_stage * CNT_W'(log2_length(length[LEN_W-1:0]));

    assign in_rdy  = (state_q == ST_RUN) && !fifo_full;
    assign accept  = in_vld && in_rdy;
    assign wr_fire = wr_rdy && fifo_vld;

    assign fifo_din = {lane_ok, lane_addr, in_data};

    butterfly_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (accept),
        .din_i  (fifo_din),
        .pop_i  (wr_rdy),
        .dout_o (fifo_dout),
        .vld_o  (fifo_vld),
        .full_o (fifo_full)
    );

    // Head register is zeroed when empty, so enables are already masked by valid.
    assign wr_vld       = fifo_vld;
    assign wr_en        = fifo_dout[ENTRY_W-1 -: P];
    assign wr_addr      = fifo_dout[DATA_BUS_W +: ADDR_BUS_W];
    assign wr_data      = fifo_dout[DATA_BUS_W-1:0];
    assign write_finish = fin_q;
    assign err_oob      = err_q;

    // Transform sequencing: beat accounting, error flag and finish pulse.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;
        fin_d    = 1'b0;

        if (accept)  acc_d    = acc_q + CNT_W'(1);
        if (wr_fire) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        if (accept && !(&lane_ok)) err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d  = ST_RUN;
                    len_d    = length[LEN_W-1:0];
                    exp_d    = start_exp;
                    acc_d    = '0;
                    wr_cnt_d = '0;
                    err_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept && ((acc_q + CNT_W'(1)) == exp_q)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wr_fire && ((wr_cnt_q + CNT_W'(1)) == exp_q)) begin
                    state_d = ST_IDLE;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
            fin_q    <= fin_d;
        end
    end

endmodule

// File: tb/tb_butterfly_wb_writer.sv
// Bench for butterfly_wb_writer: transaction-queue model checked every cycle,
// plus literal expectations on beat totals, masks and reset behaviour.
module tb_butterfly_wb_writer;

    localparam int P     = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       length = '0;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic [32*P-1:0]   in_indx = '0;
    logic [DW*P-1:0]   in_data = '0;
    logic              wr_vld;
    logic              wr_rdy = 1'b1;
    logic [P-1:0]      wr_en;
    logic [12*P-1:0]   wr_addr;
    logic [DW*P-1:0]   wr_data;
    logic              write_finish;
    logic              err_oob;

    always #5 clk = ~clk;

    butterfly_wb_writer #(
        .data_width     (DW),
        .bu_parallelism (P),
        .fifo_depth     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .length       (length),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_indx      (in_indx),
        .in_data      (in_data),
        .wr_vld       (wr_vld),
        .wr_rdy       (wr_rdy),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .write_finish (write_finish),
        .err_oob      (err_oob)
    );

    typedef struct {
        logic [12*P-1:0] addr;
        logic [DW*P-1:0] data;
        logic [P-1:0]    en;
        int              id;
    } beat_t;

    beat_t       mq[$];
    bit          m_run = 0, m_drain = 0, m_fin = 0, m_err = 0;
    logic [31:0] m_len = '0;
    int          m_exp = 0, m_acc = 0, m_wr = 0;

    int n_vec = 0, n_err = 0;
    int dut_wr = 0, dut_fin = 0;
    int oob_beat = -1;
    logic [P-1:0] cap_en = '0;
    bit  cap_seen = 0;
    int  seed = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] l);
        return (l >= 128) && (l <= 4096) && ((l & (l - 1)) == 0);
    endfunction

    // Model: beats enter a queue when the model says input is ready, leave on wr_rdy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_run = 0; m_drain = 0; m_fin = 0; m_err = 0;
            m_acc = 0; m_wr = 0; m_exp = 0; m_len = '0;
        end else begin
            bit    acc_now, pop_now;
            beat_t b;
            acc_now = in_vld && m_run && (mq.size() < DEPTH);
            pop_now = (mq.size() > 0) && wr_rdy;
            m_fin = 0;
            if (!m_run && !m_drain && start && legal(length)) begin
                m_run = 1; m_len = length;
                m_exp = (int'(length) / P) * $clog2(int'(length));
                m_acc = 0; m_wr = 0; m_err = 0;
            end
            if (pop_now) begin
                void'(mq.pop_front());
                m_wr++;
                if (m_drain && m_wr == m_exp) begin m_drain = 0; m_fin = 1; end
            end
            if (acc_now) begin
                for (int k = 0; k < P; k++) begin
                    b.addr[k*12 +: 12] = in_indx[k*32 +: 12];
                    b.en[k] = (in_indx[k*32 +: 32] < m_len);
                end
                b.data = in_data;
                b.id = m_acc;
                mq.push_back(b);
                if (b.en != {P{1'b1}}) m_err = 1;
                m_acc++;
                if (m_acc == m_exp) begin m_run = 0; m_drain = 1; end
            end
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_rdy", 256'(in_rdy), 256'(m_run && (mq.size() < DEPTH)));
            chk("wr_vld", 256'(wr_vld), 256'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("wr_en", 256'(wr_en), 256'(mq[0].en));
                chk("wr_addr", 256'(wr_addr), 256'(mq[0].addr));
                chk("wr_data", 256'(wr_data), 256'(mq[0].data));
                if (mq[0].id == oob_beat) begin cap_en = wr_en; cap_seen = 1; end
            end else begin
                chk("wr_en_idle", 256'(wr_en), 256'(0));
            end
            chk("write_finish", 256'(write_finish), 256'(m_fin));
            chk("err_oob", 256'(err_oob), 256'(m_err));
            if (wr_vld && wr_rdy) dut_wr++;
            if (write_finish) dut_fin++;
        end
    end

    task automatic drive_beat(input int len, input int obeat);
        for (int k = 0; k < P; k++) begin
            int idx;
            idx = (m_acc * P + k) % len;
            if (m_acc == obeat && k == 3) idx = 130;
            in_indx[k*32 +: 32] = 32'(idx);
            in_data[k*DW +: DW] = DW'(m_acc * 37 + k * 5 + seed);
        end
    endtask

    // One transform: start, stream beats, optional stall / mid-run start / abort.
    task automatic do_xfer(input int len, input int obeat, input int stall_at,
                           input int mid_start_at, input int abort_after, input int budget);
        int fin0;
        bit done;
        oob_beat = obeat; cap_seen = 0; cap_en = '0;
        @(posedge clk); #1;
        start = 1; length = 32'(len); in_vld = 0;
        @(posedge clk); #1;
        start = 0;
        fin0 = dut_fin; done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            wr_rdy = !(stall_at >= 0 && c >= stall_at && c < stall_at + 10);
            start  = (c == mid_start_at);
            if (c == mid_start_at) length = 32'd256;
            in_vld = 1;
            drive_beat(len, obeat);
            if (stall_at >= 0 && c == stall_at + 9) begin
                chk("stall_in_rdy_low", 256'(in_rdy), 256'(0));
                chk("stall_wr_vld_high", 256'(wr_vld), 256'(1));
            end
            @(posedge clk); #1;
            if (dut_fin != fin0) done = 1;
            if (abort_after >= 0 && m_acc >= abort_after) done = 1;
        end
        in_vld = 0; start = 0; wr_rdy = 1;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL timeout len=%0d: got no finish expected finish within %0d cycles", len, budget);
        end
    endtask

    initial begin
        int w0, f0;
        logic [31:0] bad_len [5];
        bad_len[0] = 32'd100; bad_len[1] = 32'd64; bad_len[2] = 32'd8192;
        bad_len[3] = 32'd192; bad_len[4] = 32'd0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_rdy", 256'(in_rdy), 256'(0));
        chk("rst_wr_vld", 256'(wr_vld), 256'(0));
        chk("rst_wr_en", 256'(wr_en), 256'(0));
        chk("rst_wr_addr", 256'(wr_addr), 256'(0));
        chk("rst_wr_data", 256'(wr_data), 256'(0));
        chk("rst_finish", 256'(write_finish), 256'(0));
        chk("rst_err", 256'(err_oob), 256'(0));
        rst_n = 1;

        // Length 128, free-flowing.
        seed = 1; w0 = dut_wr; f0 = dut_fin;
        do_xfer(128, -1, -1, -1, -1, 2000);
        repeat (5) @(posedge clk);
        #1;
        chk("exp_128", 256'(m_exp), 256'(112));
        chk("writes_128", 256'(dut_wr - w0), 256'(112));
        chk("finish_pulses_128", 256'(dut_fin - f0), 256'(1));
        chk("err_128", 256'(err_oob), 256'(0));

        // Backpressure for 10 cycles mid-stream.
        seed = 2; w0 = dut_wr;
        do_xfer(128, -1, 40, -1, -1, 2000);
        repeat (3) @(posedge clk);
        #1;
        chk("writes_stall", 256'(dut_wr - w0), 256'(112));

        // One out-of-range lane index.
        seed = 3;
        do_xfer(128, 5, -1, -1, -1, 2000);
        repeat (5) @(posedge clk);
        #1;
        chk("oob_seen", 256'(cap_seen), 256'(1));
        chk("oob_wr_en", 256'(cap_en), 256'(8'hF7));
        chk("oob_sticky", 256'(err_oob), 256'(1));

        // Illegal lengths: stay idle, error flag untouched.
        foreach (bad_len[i]) begin
            @(posedge clk); #1;
            start = 1; length = bad_len[i]; in_vld = 1;
            @(posedge clk); #1;
            start = 0;
            repeat (4) @(posedge clk);
            #1;
            chk("illegal_in_rdy", 256'(in_rdy), 256'(0));
        end
        in_vld = 0;
        chk("illegal_err_kept", 256'(err_oob), 256'(1));

        // Start pulse during RUN is ignored; legal start clears the error.
        seed = 4; w0 = dut_wr; f0 = dut_fin;
        do_xfer(128, -1, -1, 30, -1, 2000);
        repeat (3) @(posedge clk);
        #1;
        chk("writes_midstart", 256'(dut_wr - w0), 256'(112));
        chk("finish_midstart", 256'(dut_fin - f0), 256'(1));
        chk("err_cleared", 256'(err_oob), 256'(0));

        // Reset after 50 accepted beats of a 256-point transform.
        seed = 5;
        do_xfer(256, -1, -1, -1, 50, 3000);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_in_rdy", 256'(in_rdy), 256'(0));
        chk("abort_wr_vld", 256'(wr_vld), 256'(0));
        chk("abort_wr_en", 256'(wr_en), 256'(0));
        chk("abort_wr_addr", 256'(wr_addr), 256'(0));
        chk("abort_wr_data", 256'(wr_data), 256'(0));
        chk("abort_finish", 256'(write_finish), 256'(0));
        chk("abort_err", 256'(err_oob), 256'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        f0 = dut_fin;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_finish", 256'(dut_fin - f0), 256'(0));
        seed = 6; w0 = dut_wr; f0 = dut_fin;
        do_xfer(256, -1, -1, -1, -1, 3000);
        repeat (3) @(posedge clk);
        #1;
        chk("exp_256", 256'(m_exp), 256'(256));
        chk("writes_256", 256'(dut_wr - w0), 256'(256));
        chk("finish_256", 256'(dut_fin - f0), 256'(1));

        // Largest transform.
        seed = 7; w0 = dut_wr;
        do_xfer(4096, -1, -1, -1, -1, 8000);
        repeat (3) @(posedge clk);
        #1;
        chk("exp_4096", 256'(m_exp), 256'(6144));
        chk("writes_4096", 256'(dut_wr - w0), 256'(6144));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
